// File: rtl/alu_result_stage.sv
// ALU result stage: a two-entry skid buffer that registers ALU results
// and keeps the architectural NZCV flags, a sticky overflow bit and a
// commit counter. All architectural state updates only when a result
// leaves the stage (out_valid && out_ready).
module alu_result_stage #(
  parameter int M = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_y,
  input  logic [3:0]   in_flags,
  input  logic [2:0]   in_op,
  input  logic         in_flag_we,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_y,
  output logic [3:0]   out_flags,
  output logic [2:0]   out_op,
  output logic [3:0]   flags_q,
  output logic         sticky_v,
  input  logic         clear_sticky,
  output logic [7:0]   commit_count
);

  logic         accept;
  logic         commit;
  logic         main_free;
  logic         main_we;
  logic         skid_full;
  logic         skid_full_next;
  logic [M-1:0] skid_y;
  logic [3:0]   skid_flags;
  logic [2:0]   skid_op;
  logic         skid_we;

  assign accept    = in_valid && in_ready;
  assign commit    = out_valid && out_ready;
  assign main_free = !out_valid || commit;

  // Skid occupancy for the next cycle; in_ready is registered from this so
  // it never sees out_ready combinationally.
  always_comb begin
    skid_full_next = skid_full;
    if (main_free) begin
      skid_full_next = skid_full && accept;
    end else if (accept) begin
      skid_full_next = 1'b1;
    end
  end

  // Main and skid registers: the main register refills from the skid entry
  // first so ordering is preserved, otherwise directly from the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_flags  <= '0;
      out_op     <= '0;
      main_we    <= 1'b0;
      skid_full  <= 1'b0;
      skid_y     <= '0;
      skid_flags <= '0;
      skid_op    <= '0;
      skid_we    <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      skid_full <= skid_full_next;
      in_ready  <= !skid_full_next;
      if (main_free) begin
        if (skid_full) begin
          out_valid <= 1'b1;
          out_y     <= skid_y;
          out_flags <= skid_flags;
          out_op    <= skid_op;
          main_we   <= skid_we;
          if (accept) begin
            skid_y     <= in_y;
            skid_flags <= in_flags;
            skid_op    <= in_op;
            skid_we    <= in_flag_we;
          end
        end else begin
          out_valid <= accept;
          if (accept) begin
            out_y     <= in_y;
            out_flags <= in_flags;
            out_op    <= in_op;
            main_we   <= in_flag_we;
          end
        end
      end else if (accept) begin
        skid_y     <= in_y;
        skid_flags <= in_flags;
        skid_op    <= in_op;
        skid_we    <= in_flag_we;
      end
    end
  end

  // Architectural state driven by commits; a V=1 commit beats clear_sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q      <= '0;
      sticky_v     <= 1'b0;
      commit_count <= '0;
    end else begin
      if (commit) begin
        commit_count <= commit_count + 8'd1;
        if (main_we) begin
          flags_q <= out_flags;
        end
      end
      if (commit && out_flags[0]) begin
        sticky_v <= 1'b1;
      end else if (clear_sticky) begin
        sticky_v <= 1'b0;
      end
    end
  end

endmodule
